// File: rtl/rsa_spi_pkg.sv
// rtl/rsa_spi_pkg.sv - shared constants for the RSA SPI register master
package rsa_spi_pkg;

  // Command byte layout: write flag in the MSB, register address in the low bits
  localparam int CMD_W      = 8;
  localparam int CMD_WR_BIT = 7;

  // Frame sequencer states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;

  // RSA register bank map
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_ACTIONS = 3'd1;
  localparam logic [2:0] ADDR_P       = 3'd2;
  localparam logic [2:0] ADDR_E       = 3'd3;
  localparam logic [2:0] ADDR_M       = 3'd4;
  localparam logic [2:0] ADDR_CONST   = 3'd5;
  localparam logic [2:0] ADDR_C       = 3'd6;
  localparam logic [2:0] ADDR_SPARE   = 3'd7;

  // Build the command byte from the write flag and a zero-extended address
  function automatic logic [CMD_W-1:0] build_cmd(input logic write, input logic [6:0] addr7);
    logic [CMD_W-1:0] c;
    c             = {1'b0, addr7};
    c[CMD_WR_BIT] = write;
    return c;
  endfunction

endpackage

// File: rtl/spim_baud_gen.sv
// rtl/spim_baud_gen.sv - SCLK half-period counter, ticks on the last clk of each half period
module spim_baud_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       ena,
  input  logic                       run,
  output logic                       tick,
  output logic [$clog2(CLK_DIV)-1:0] cnt
);

  localparam int                 CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Count 0..CLK_DIV-1 while a frame runs; parked at zero when idle, frozen when disabled
  always_comb begin
    cnt_d = cnt_q;
    if (ena) begin
      if (!run || cnt_q == LAST) cnt_d = '0;
      else                       cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = ena & run & (cnt_q == LAST);
  assign cnt  = cnt_q;

endmodule

// File: rtl/spi_reg_master.sv
// rtl/spi_reg_master.sv - mode-0 SPI initiator for single-register RSA bank frames (option: SPIM_MISO_SYNC_EN)
module spi_reg_master #(
  parameter int REG_W   = 8,
  parameter int ADDR_W  = 3,
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [REG_W-1:0]  cmd_wdata,
  output logic              rsp_valid,
  output logic [REG_W-1:0]  rsp_rdata,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  import rsa_spi_pkg::*;

  localparam int FRAME_W = CMD_W + REG_W;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int CNT_W   = $clog2(CLK_DIV);

  logic             tick;
  logic [CNT_W-1:0] phase_cnt;
  logic             miso_s;

`ifdef SPIM_MISO_SYNC_EN
  // Synchronised MISO lags by two clks, so capture two clks into the high phase
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(2);
  logic [1:0] sync_d, sync_q;

  // Two-flop MISO synchroniser, free running
  always_comb sync_d = {sync_q[0], spi_miso};

  // Synchroniser registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign miso_s = sync_q[1];
`else
  // MISO captured directly in the first clk of the SCLK high phase
  localparam logic [CNT_W-1:0] SAMPLE_CNT = '0;
  assign miso_s = spi_miso;
`endif

  state_t              state_d, state_q;
  logic                cs_n_d, cs_n_q;
  logic                sclk_d, sclk_q;
  logic                mosi_d, mosi_q;
  logic [FRAME_W-2:0]  tx_d, tx_q;
  logic [BIT_W-1:0]    bit_d, bit_q;
  logic [REG_W-1:0]    rx_d, rx_q;
  logic                rsp_valid_d, rsp_valid_q;
  logic [REG_W-1:0]    rsp_rdata_d, rsp_rdata_q;
  logic [FRAME_W-1:0]  frame;
  logic                accept;
  logic                sample_en;

  spim_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk  (clk),
    .rstb (rstb),
    .ena  (ena),
    .run  (state_q != ST_IDLE),
    .tick (tick),
    .cnt  (phase_cnt)
  );

  assign cmd_ready = ena & (state_q == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign frame     = {build_cmd(cmd_write, 7'(cmd_addr)), (cmd_write ? cmd_wdata : {REG_W{1'b0}})};
  assign sample_en = ena & (state_q == ST_SHIFT) & sclk_q & (phase_cnt == SAMPLE_CNT);

  // Frame sequencer: every phase advances on a baud tick, so ena=0 freezes everything
  always_comb begin
    state_d     = state_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    tx_d        = tx_q;
    bit_d       = bit_q;
    rx_d        = rx_q;
    rsp_valid_d = ena ? 1'b0 : rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          cs_n_d  = 1'b0;
          mosi_d  = frame[FRAME_W-1];
          tx_d    = frame[FRAME_W-2:0];
          bit_d   = BIT_W'(FRAME_W - 1);
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        // Only the last REG_W samples survive; command-phase bits fall off the top
        if (sample_en) rx_d = {rx_q[REG_W-2:0], miso_s};
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q != '0) begin
              mosi_d = tx_q[FRAME_W-2];
              tx_d   = {tx_q[FRAME_W-3:0], 1'b0};
            end
          end else if (bit_q == '0) begin
            state_d = ST_HOLD;
          end else begin
            bit_d  = bit_q - BIT_W'(1);
            sclk_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d     = ST_GAP;
          cs_n_d      = 1'b1;
          mosi_d      = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rx_q;
        end
      end
      ST_GAP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and output registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      tx_q        <= '0;
      bit_q       <= '0;
      rx_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      tx_q        <= tx_d;
      bit_q       <= bit_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign spi_cs_n  = cs_n_q;
  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
